// File: rtl/traffic_ctrl_param.sv
// Two-road traffic light controller: shared tick prescaler and phase timer,
// demand-actuated greens with gap-out, all-red clearance and maintenance flash.
module traffic_ctrl_param #(
    parameter int unsigned TICK_DIV     = 4,
    parameter int unsigned CNT_W        = 6,
    parameter int unsigned NS_GREEN_MIN = 8,
    parameter int unsigned EW_GREEN_MIN = 3,
    parameter int unsigned EW_GREEN_MAX = 12,
    parameter int unsigned YELLOW_T     = 3,
    parameter int unsigned ALLRED_T     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ns_detect,
    input  logic             ew_detect,
    input  logic             force_flash,
    output logic             ns_red,
    output logic             ns_yellow,
    output logic             ns_green,
    output logic             ew_red,
    output logic             ew_yellow,
    output logic             ew_green,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] phase_timer
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned E_W   = CNT_W + 1;

    localparam logic [2:0] ST_NS_GREEN  = 3'd0;
    localparam logic [2:0] ST_NS_YELLOW = 3'd1;
    localparam logic [2:0] ST_ALL_RED_A = 3'd2;
    localparam logic [2:0] ST_EW_GREEN  = 3'd3;
    localparam logic [2:0] ST_EW_YELLOW = 3'd4;
    localparam logic [2:0] ST_ALL_RED_B = 3'd5;
    localparam logic [2:0] ST_FLASH     = 3'd6;

    // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
    localparam logic [5:0] LAMPS_RST = 6'b100_100;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_timer;
    logic [PRE_W-1:0] r_pre;
    logic             r_flash;
    logic [5:0]       r_lamps;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [PRE_W-1:0] w_pre_nxt;
    logic             w_flash_nxt;
    logic [5:0]       w_lamps_nxt;
    logic             w_tick;
    logic             w_go;
    logic [2:0]       w_go_state;
    logic [E_W-1:0]   w_e;
    logic [CNT_W-1:0] w_timer_sat;
    logic             w_unused;

    // ns_detect is reserved; it does not influence phasing
    assign w_unused = ns_detect;

    // State, timer, prescaler and lamp registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ALL_RED_B;
            r_timer <= '0;
            r_pre   <= '0;
            r_flash <= 1'b0;
            r_lamps <= LAMPS_RST;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_pre   <= w_pre_nxt;
            r_flash <= w_flash_nxt;
            r_lamps <= w_lamps_nxt;
        end
    end

    assign w_tick      = (r_pre == PRE_W'(TICK_DIV - 1));
    assign w_e         = {1'b0, r_timer} + E_W'(1);
    assign w_timer_sat = (&r_timer) ? r_timer : w_e[CNT_W-1:0];

    // Tick-qualified transition condition for each normal phase
    always_comb begin
        w_go       = 1'b0;
        w_go_state = r_state;
        case (r_state)
            ST_NS_GREEN: begin
                w_go       = (w_e >= E_W'(NS_GREEN_MIN)) && ew_detect;
                w_go_state = ST_NS_YELLOW;
            end
            ST_NS_YELLOW: begin
                w_go       = (w_e == E_W'(YELLOW_T));
                w_go_state = ST_ALL_RED_A;
            end
            ST_ALL_RED_A: begin
                w_go       = (w_e == E_W'(ALLRED_T));
                w_go_state = ST_EW_GREEN;
            end
            ST_EW_GREEN: begin
                w_go       = (w_e == E_W'(EW_GREEN_MAX)) ||
                             ((w_e >= E_W'(EW_GREEN_MIN)) && !ew_detect);
                w_go_state = ST_EW_YELLOW;
            end
            ST_EW_YELLOW: begin
                w_go       = (w_e == E_W'(YELLOW_T));
                w_go_state = ST_ALL_RED_B;
            end
            ST_ALL_RED_B: begin
                w_go       = (w_e == E_W'(ALLRED_T));
                w_go_state = ST_NS_GREEN;
            end
            default: begin
                w_go       = 1'b0;
                w_go_state = r_state;
            end
        endcase
    end

    // Next-state: illegal recovery, flash entry/exit, then ticked phasing
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_pre_nxt   = w_tick ? '0 : r_pre + PRE_W'(1);
        w_flash_nxt = r_flash;
        if (r_state > ST_FLASH) begin
            w_state_nxt = ST_ALL_RED_B;
            w_timer_nxt = '0;
        end else if (r_state == ST_FLASH) begin
            w_timer_nxt = '0;
            if (!force_flash) begin
                w_state_nxt = ST_ALL_RED_B;
                w_pre_nxt   = '0;
            end else if (w_tick) begin
                w_flash_nxt = !r_flash;
            end
        end else if (force_flash) begin
            w_state_nxt = ST_FLASH;
            w_timer_nxt = '0;
            w_pre_nxt   = '0;
            w_flash_nxt = 1'b1;
        end else if (w_tick) begin
            if (w_go) begin
                w_state_nxt = w_go_state;
                w_timer_nxt = '0;
            end else begin
                w_timer_nxt = w_timer_sat;
            end
        end
    end

    // Lamp decode of the next state so lamps switch together with state
    always_comb begin
        w_lamps_nxt = LAMPS_RST;
        case (w_state_nxt)
            ST_NS_GREEN:  w_lamps_nxt = 6'b001_100;
            ST_NS_YELLOW: w_lamps_nxt = 6'b010_100;
            ST_ALL_RED_A: w_lamps_nxt = 6'b100_100;
            ST_EW_GREEN:  w_lamps_nxt = 6'b100_001;
            ST_EW_YELLOW: w_lamps_nxt = 6'b100_010;
            ST_ALL_RED_B: w_lamps_nxt = 6'b100_100;
            ST_FLASH:     w_lamps_nxt = {1'b0, w_flash_nxt, 1'b0, w_flash_nxt, 2'b00};
            default:      w_lamps_nxt = LAMPS_RST;
        endcase
    end

    assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = r_lamps;
    assign state       = r_state;
    assign phase_timer = r_timer;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed-vector bench for traffic_ctrl_param with per-cycle lamp invariants.
module tb_traffic_ctrl_param;

    localparam int unsigned CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             ns_detect;
    logic             ew_detect;
    logic             force_flash;
    logic             ns_red, ns_yellow, ns_green;
    logic             ew_red, ew_yellow, ew_green;
    logic [2:0]       state;
    logic [CNT_W-1:0] phase_timer;

    int n_vec = 0;
    int n_err = 0;
    logic inv_en = 1'b0;

    traffic_ctrl_param #(
        .TICK_DIV(2), .CNT_W(CNT_W), .NS_GREEN_MIN(4), .EW_GREEN_MIN(2),
        .EW_GREEN_MAX(5), .YELLOW_T(2), .ALLRED_T(1)
    ) dut (
        .clk(clk), .rst(rst), .ns_detect(ns_detect), .ew_detect(ew_detect),
        .force_flash(force_flash),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .state(state), .phase_timer(phase_timer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
    task automatic chk_st(input string tag, input logic [2:0] exp_st, input logic [5:0] exp_lamps);
        chk({tag, "_state"}, 32'(state), 32'(exp_st));
        chk({tag, "_lamps"}, 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}),
            32'(exp_lamps));
    endtask

    function automatic logic legal_move(input logic [2:0] p, input logic [2:0] c);
        logic [2:0] succ;
        succ = (p == 3'd5) ? 3'd0 : p + 3'd1;
        return (c == p) || (c == 3'd6) || (p == 3'd6 && c == 3'd5) ||
               (p < 3'd6 && c == succ);
    endfunction

    // Safety invariants sampled on the falling edge
    logic [2:0] prev_st;
    logic       rst_q;
    logic       armed = 1'b0;
    always @(negedge clk) begin
        if (inv_en) begin
            chk("inv_conflict", 32'((ns_green | ns_yellow) & (ew_green | ew_yellow)), 32'd0);
            if (state != 3'd6) begin
                chk("inv_ns_one", 32'(ns_red) + 32'(ns_yellow) + 32'(ns_green), 32'd1);
                chk("inv_ew_one", 32'(ew_red) + 32'(ew_yellow) + 32'(ew_green), 32'd1);
            end
            if (armed && !rst_q)
                chk("inv_sequence", 32'(legal_move(prev_st, state)), 32'd1);
            armed   = 1'b1;
            prev_st = state;
            rst_q   = rst;
        end
    end

    initial begin
        rst = 1'b1; ns_detect = 1'b0; ew_detect = 1'b0; force_flash = 1'b0;
        step(3);
        chk_st("rst", 3'd5, 6'b100_100);
        chk("rst_timer", 32'(phase_timer), 32'd0);
        inv_en = 1'b1;

        // 1: release reset, NS green two clocks later
        rst = 1'b0;
        step(1);
        chk_st("s1_wait", 3'd5, 6'b100_100);
        step(1);
        chk_st("s1_nsg", 3'd0, 6'b001_100);
        chk("s1_timer", 32'(phase_timer), 32'd0);

        // 2: no EW demand, rest in NS green with saturating timer
        step(300);
        chk_st("s2_rest", 3'd0, 6'b001_100);
        chk("s2_sat", 32'(phase_timer), 32'd63);

        // 3: EW demand from NS green entry, EW green runs to max
        rst = 1'b1;
        step(1);
        rst = 1'b0; ew_detect = 1'b1;
        step(2);
        chk_st("s3_nsg", 3'd0, 6'b001_100);
        step(7);
        chk_st("s3_nsg_hold", 3'd0, 6'b001_100);
        step(1);
        chk_st("s3_nsy", 3'd1, 6'b010_100);
        step(4);
        chk_st("s3_ara", 3'd2, 6'b100_100);
        step(2);
        chk_st("s3_ewg", 3'd3, 6'b100_001);
        step(9);
        chk_st("s3_ewg_late", 3'd3, 6'b100_001);
        chk("s3_ewg_timer", 32'(phase_timer), 32'd4);
        step(1);
        chk_st("s3_ewy", 3'd4, 6'b100_010);
        step(4);
        chk_st("s3_arb", 3'd5, 6'b100_100);
        step(2);
        chk_st("s3_nsg2", 3'd0, 6'b001_100);

        // 4a: gap-out after one tick of EW green
        step(14);
        chk_st("s4a_ewg", 3'd3, 6'b100_001);
        step(2);
        chk("s4a_timer", 32'(phase_timer), 32'd1);
        ew_detect = 1'b0;
        step(2);
        chk_st("s4a_gap", 3'd4, 6'b100_010);
        step(6);
        chk_st("s4a_nsg", 3'd0, 6'b001_100);

        // 4b: demand dropped at EW green entry, minimum still enforced
        ew_detect = 1'b1;
        step(14);
        chk_st("s4b_ewg", 3'd3, 6'b100_001);
        ew_detect = 1'b0;
        step(2);
        chk_st("s4b_min", 3'd3, 6'b100_001);
        chk("s4b_timer", 32'(phase_timer), 32'd1);
        step(2);
        chk_st("s4b_gap", 3'd4, 6'b100_010);
        step(6);
        chk_st("s4b_nsg", 3'd0, 6'b001_100);

        // 5: flash request mid EW green, on a tick edge
        ew_detect = 1'b1;
        step(15);
        chk_st("s5_ewg", 3'd3, 6'b100_001);
        force_flash = 1'b1;
        step(1);
        chk_st("s5_fl_on", 3'd6, 6'b010_100);
        chk("s5_fl_timer", 32'(phase_timer), 32'd0);
        step(1);
        chk_st("s5_fl_hold", 3'd6, 6'b010_100);
        step(1);
        chk_st("s5_fl_off", 3'd6, 6'b000_000);
        step(2);
        chk_st("s5_fl_on2", 3'd6, 6'b010_100);
        force_flash = 1'b0;
        step(1);
        chk_st("s5_exit", 3'd5, 6'b100_100);
        chk("s5_exit_timer", 32'(phase_timer), 32'd0);
        step(1);
        chk_st("s5_exit_wait", 3'd5, 6'b100_100);
        step(1);
        chk_st("s5_nsg", 3'd0, 6'b001_100);

        // 6: one-cycle reset during NS yellow
        step(8);
        chk_st("s6_nsy", 3'd1, 6'b010_100);
        rst = 1'b1;
        step(1);
        chk_st("s6_rst", 3'd5, 6'b100_100);
        chk("s6_timer", 32'(phase_timer), 32'd0);
        rst = 1'b0;
        step(1);
        chk_st("s6_wait", 3'd5, 6'b100_100);
        step(1);
        chk_st("s6_nsg", 3'd0, 6'b001_100);

        inv_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
